// File: rtl/fc_pkg.sv
// ----------------------------------------------------------------------------
// fc_pkg
// Shared constants and types for the fully-connected classifier stage.
//   N_IN        number of pooled input elements (3x3x3)
//   ROM_STRIDE  weight ROM words per neuron (27 weights + 1 bias)
//   POOL_W      width of the packed pooled input map
//   K_BIAS      k index that addresses the bias word
//   state_e     controller states
//   elem_idx    flat element index of pooled element (d, r, c)
// ----------------------------------------------------------------------------
package fc_pkg;

    localparam int unsigned N_IN       = 27;
    localparam int unsigned ROM_STRIDE = 28;
    localparam int unsigned POOL_W     = N_IN * 8;
    localparam logic [4:0]  K_BIAS     = 5'(ROM_STRIDE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDrain,
        StStore
    } state_e;

    function automatic int unsigned elem_idx(input int unsigned d, input int unsigned r,
                                             input int unsigned c);
        return d * 9 + r * 3 + c;
    endfunction

endpackage

// File: rtl/fc_layer_if.sv
// ----------------------------------------------------------------------------
// fc_layer_if
// Bundles the pooled-input handshake, weight ROM port and result bus of
// fc_layer.
//   in_vld    pool_lin valid this cycle              (master -> slave)
//   pool_lin  27 x u8 pooled map, element i at [i*8 +: 8] (master -> slave)
//   w_data    signed ROM data, one cycle after w_rd  (master -> slave)
//   w_rd      ROM read enable                        (slave -> master)
//   w_addr    ROM address j*28+k                     (slave -> master)
//   busy      frame in progress                      (slave -> master)
//   fc_lin    N_OUT x s8 results, neuron j at [j*8 +: 8] (slave -> master)
//   out_vld   one-cycle result strobe                (slave -> master)
// ----------------------------------------------------------------------------
interface fc_layer_if #(
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned ADDR_W = 9
);
    import fc_pkg::*;

    logic                  in_vld;
    logic [POOL_W-1:0]     pool_lin;
    logic [7:0]            w_data;
    logic                  w_rd;
    logic [ADDR_W-1:0]     w_addr;
    logic                  busy;
    logic [N_OUT*8-1:0]    fc_lin;
    logic                  out_vld;

    modport master (
        output in_vld, pool_lin, w_data,
        input  w_rd, w_addr, busy, fc_lin, out_vld
    );

    modport slave (
        input  in_vld, pool_lin, w_data,
        output w_rd, w_addr, busy, fc_lin, out_vld
    );

endinterface

// File: rtl/fc_requant.sv
// ----------------------------------------------------------------------------
// fc_requant
// Combinational requantizer: floor arithmetic right shift of the signed
// accumulator by SHIFT, then saturation to the signed 8-bit range.
//   acc_i  signed accumulator, ACC_W bits
//   q_o    saturated signed 8-bit result
// ----------------------------------------------------------------------------
module fc_requant #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [7:0]       q_o
);

    localparam logic signed [ACC_W-1:0] MAX_V = 127;
    localparam logic signed [ACC_W-1:0] MIN_V = -128;

    logic signed [ACC_W-1:0] t;

    always_comb begin
        t = acc_i >>> SHIFT;
        if (t > MAX_V) begin
            q_o = 8'h7F;
        end else if (t < MIN_V) begin
            q_o = 8'h80;
        end else begin
            q_o = t[7:0];
        end
    end

endmodule

// File: rtl/fc_layer.sv
// ----------------------------------------------------------------------------
// fc_layer
// Fully-connected classifier stage. Captures one pooled 27-element map, then
// evaluates N_OUT neurons one after another with one MAC per cycle, streaming
// 27 weights plus a bias per neuron from an external 1-cycle-latency ROM.
// All results are presented together on fc_lin with a one-cycle out_vld.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   fc_layer_if slave: in_vld/pool_lin in, w_rd/w_addr out, w_data in,
//         busy/fc_lin/out_vld out
// Per neuron: 28 MAC cycles (ROM reads), 1 DRAIN cycle, 1 STORE cycle.
// ----------------------------------------------------------------------------
module fc_layer
    import fc_pkg::*;
#(
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned SHIFT  = 7,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned ADDR_W = 9
) (
    input logic       clk,
    input logic       rst,
    fc_layer_if.slave bus
);

    localparam int unsigned    JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [JW-1:0]  J_LAST = JW'(N_OUT - 1);

    state_e                  state_q, state_d;
    logic [JW-1:0]           j_q, j_d;
    logic [4:0]              k_q, k_d;
    // k of the ROM word arriving on w_data this cycle, and whether one arrives
    logic [4:0]              kp_q, kp_d;
    logic                    mac_vld_q, mac_vld_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              x_q [N_IN];
    logic [7:0]              x_d [N_IN];
    logic [N_OUT*8-1:0]      fc_q, fc_d;
    logic                    out_vld_q, out_vld_d;
    logic                    w_rd;

    logic [7:0]              x_sel;
    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] term;
    logic [7:0]              q_res;

    fc_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc_i (acc_q),
        .q_o   (q_res)
    );

    // Datapath term for the ROM word now on w_data: weight product or bias.
    always_comb begin
        x_sel = (kp_q == K_BIAS) ? 8'd0 : x_q[kp_q];
        prod  = $signed({1'b0, x_sel}) * $signed(bus.w_data);
        if (kp_q == K_BIAS) begin
            term = {{(ACC_W-8){bus.w_data[7]}}, bus.w_data};
        end else begin
            term = {{(ACC_W-17){prod[16]}}, prod};
        end
    end

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        k_d       = k_q;
        kp_d      = k_q;
        mac_vld_d = 1'b0;
        addr_d    = addr_q;
        acc_d     = acc_q;
        x_d       = x_q;
        fc_d      = fc_q;
        out_vld_d = 1'b0;
        w_rd      = 1'b0;

        if (mac_vld_q) begin
            acc_d = acc_q + term;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.in_vld) begin
                    for (int unsigned d = 0; d < 3; d++) begin
                        for (int unsigned r = 0; r < 3; r++) begin
                            for (int unsigned c = 0; c < 3; c++) begin
                                x_d[elem_idx(d, r, c)] =
                                    bus.pool_lin[elem_idx(d, r, c) * 8 +: 8];
                            end
                        end
                    end
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    addr_d  = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                w_rd      = 1'b1;
                mac_vld_d = 1'b1;
                if (k_q == K_BIAS) begin
                    // Address stays on the bias word so w_addr holds its last value.
                    state_d = StDrain;
                end else begin
                    k_d    = k_q + 5'd1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                state_d = StStore;
            end
            StStore: begin
                for (int s = 0; s < int'(N_OUT); s++) begin
                    if (j_q == JW'(s)) begin
                        fc_d[s*8 +: 8] = q_res;
                    end
                end
                acc_d = '0;
                k_d   = '0;
                if (j_q == J_LAST) begin
                    out_vld_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    j_d     = j_q + JW'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StMac;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            j_q       <= '0;
            k_q       <= '0;
            kp_q      <= '0;
            mac_vld_q <= 1'b0;
            addr_q    <= '0;
            acc_q     <= '0;
            x_q       <= '{default: '0};
            fc_q      <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            kp_q      <= kp_d;
            mac_vld_q <= mac_vld_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            fc_q      <= fc_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign bus.w_rd    = w_rd;
    assign bus.w_addr  = addr_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.fc_lin  = fc_q;
    assign bus.out_vld = out_vld_q;

endmodule
